// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - parallel-to-serial stage feeding a bit-serial sequence detector
//
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per clock on x. Consecutive words stream with no idle gap.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] sent first, 0: din[0] sent first
//   IDLE_BIT   value driven on x whenever x_valid = 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   din_valid  in   upstream word available
//   din        in   word to serialize, sampled only on accept
//   din_ready  out  block can accept a word this cycle (combinational)
//   x          out  serial bit stream (registered)
//   x_valid    out  x carries a frame bit this cycle (registered)
//   last       out  x carries the final bit of the current frame (registered)
//
// Build option:
//   PARITY_EN  when defined, an even-parity bit (^din) follows the data bits
//              and carries last; frame length becomes WIDTH+1.

module seq_bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last
);

`ifdef PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FLEN);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FLEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
    localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH);
`endif

    logic [1:0]       r_state;
    // Holds the bits still to be sent after the one currently on x,
    // always arranged so the next bit sits in the top position.
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_x;
    logic             r_x_valid;
    logic             r_last;
`ifdef PARITY_EN
    logic             r_parity;
`endif

    logic             w_accept;
    logic [WIDTH-1:0] w_din_ord;
    logic [CNT_W-1:0] w_cnt_next;

    // Ready in IDLE, or while the final frame bit is on x so the next word
    // can follow without a gap. Never ready during reset.
    assign din_ready  = ~rst & ((r_state == S_IDLE) | r_last);
    assign w_accept   = din_valid & din_ready;
    assign w_cnt_next = r_cnt + 1'b1;

    // Reorder the incoming word so that transmission order is always
    // top bit first; the shifter then only ever shifts left.
    always_comb begin
        w_din_ord = din;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_din_ord[i] = din[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
`ifdef PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_accept) begin
            // New frame: first bit goes straight to x, whether from IDLE or
            // directly after the previous frame's last bit.
            r_state   <= S_SHIFT;
            r_shift   <= w_din_ord[WIDTH-2:0];
            r_cnt     <= '0;
            r_x       <= w_din_ord[WIDTH-1];
            r_x_valid <= 1'b1;
            r_last    <= 1'b0;
`ifdef PARITY_EN
            r_parity  <= ^din;
`endif
        end else if (r_last) begin
            // Frame finished and no follow-on word: drop to idle.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_cnt <= w_cnt_next;
`ifdef PARITY_EN
            if (w_cnt_next == PAR_IDX) begin
                r_state <= S_PAR;
                r_x     <= r_parity;
                r_last  <= 1'b1;
            end else begin
                r_x     <= r_shift[WIDTH-2];
                r_shift <= r_shift << 1;
                r_last  <= (w_cnt_next == LAST_IDX);
            end
`else
            r_x     <= r_shift[WIDTH-2];
            r_shift <= r_shift << 1;
            r_last  <= (w_cnt_next == LAST_IDX);
`endif
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign last    = r_last;

endmodule
